// File: rtl/alu_addsub_pipe.sv
// ============================================================================
// alu_addsub_pipe : 2-stage valid/ready add/sub with accumulator and flags.
// Optional clamp on signed overflow: define SATURATE_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module alu_addsub_pipe #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [WIDTH-1:0] acc_out
);

  localparam int         c_MSB          = WIDTH - 1;
  localparam logic [2:0] c_OP_SUB       = 3'b001;
  localparam logic [2:0] c_OP_ACC_ADD   = 3'b010;
  localparam logic [2:0] c_OP_ACC_SUB   = 3'b011;
  localparam logic [2:0] c_OP_ACC_LOAD  = 3'b100;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             w_adv2, w_in_xfer;
  logic [WIDTH-1:0] w_x, w_y, w_y_eff, w_res;
  logic             w_sub, w_acc_op, w_load, w_ovf_raw, w_c, w_ovf;
  logic [WIDTH:0]   w_sum;

  assign w_adv2    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || w_adv2;
  assign w_in_xfer = in_valid && in_ready;

  // Operand selection; reserved opcodes fall through to plain ADD.
  always_comb begin
    w_x      = s1_a_q;
    w_y      = s1_b_q;
    w_sub    = 1'b0;
    w_acc_op = 1'b0;
    w_load   = 1'b0;
    case (s1_op_q)
      c_OP_SUB:      w_sub = 1'b1;
      c_OP_ACC_ADD:  begin w_x = acc_q; w_y = s1_a_q; w_acc_op = 1'b1; end
      c_OP_ACC_SUB:  begin w_x = acc_q; w_y = s1_a_q; w_acc_op = 1'b1; w_sub = 1'b1; end
      c_OP_ACC_LOAD: begin w_acc_op = 1'b1; w_load = 1'b1; end
      default:       ;
    endcase
  end

  assign w_y_eff   = w_sub ? ~w_y : w_y;
  assign w_sum     = {1'b0, w_x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf_raw = (w_x[c_MSB] == w_y_eff[c_MSB]) && (w_sum[c_MSB] != w_x[c_MSB]);

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    w_c   = w_sum[WIDTH];
    w_ovf = w_ovf_raw;
    if (w_load) begin
      w_res = s1_a_q;
      w_c   = 1'b0;
      w_ovf = 1'b0;
    end
`ifdef SATURATE_EN
    // Overflow direction follows the sign shared by both effective operands.
    else if (w_ovf_raw) begin
      w_res = w_x[c_MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    if (w_in_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (w_adv2) begin
      s1_valid_d = 1'b0;
    end
    if (w_adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = w_res;
        c_out_d  = w_c;
        ovf_d    = w_ovf;
        zero_d   = (w_res == '0);
        neg_d    = w_res[c_MSB];
        if (w_acc_op) acc_d = w_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      acc_q      <= ACC_INIT;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign acc_out   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_addsub_pipe.sv
// ============================================================================
// tb_alu_addsub_pipe : directed self-checking bench for alu_addsub_pipe (WIDTH=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       c_out, ovf, zero, neg;
  logic [3:0] acc_out;

  int n_tests = 0;
  int n_fail  = 0;

  alu_addsub_pipe #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg),
    .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat through an empty pipe with out_ready=1; checks latency and flags.
  task automatic run1(input string tag, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                      input logic [3:0] er, input logic ec, input logic eo, input logic ez, input logic en);
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0;
    chk({tag, "_ov_lat1"}, out_valid, 1'b0);
    step();
    chk({tag, "_ov_lat2"}, out_valid, 1'b1);
    chk({tag, "_res"},  result, er);
    chk({tag, "_cout"}, c_out, ec);
    chk({tag, "_ovf"},  ovf, eo);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_neg"},  neg, en);
    step();
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = 4'h0; b = 4'h0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result",    result, 4'h0);
    chk("rst_acc",       acc_out, 4'h0);
    chk("rst_in_ready",  in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // result, c_out, ovf, zero, neg
    run1("add0",    3'b000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run1("subFF",   3'b001, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run1("sub21",   3'b001, 4'h2, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    run1("sub12",   3'b001, 4'h1, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SATURATE_EN
    run1("add71",   3'b000, 4'h7, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    run1("add71",   3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    run1("addCC",   3'b000, 4'hC, 4'hC, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1);
    run1("rsvd111", 3'b111, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("acc_untouched", acc_out, 4'h0);

    // Backpressure: third beat refused while both stages are full.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b000; a = 4'h1; b = 4'h2;
    chk("bp_ready_a", in_ready, 1'b1);
    step();
    op = 3'b001; a = 4'h5; b = 4'h3;
    chk("bp_ready_b", in_ready, 1'b1);
    step();
    op = 3'b000; a = 4'h2; b = 4'h2;
    chk("bp_ready_c0", in_ready, 1'b0);
    chk("bp_ov_a",     out_valid, 1'b1);
    step();
    chk("bp_ready_c1", in_ready, 1'b0);
    chk("bp_hold_a",   result, 4'h3);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_c2", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_ov_b",  out_valid, 1'b1);
    chk("bp_res_b", result, 4'h2);
    step();
    chk("bp_ov_c",  out_valid, 1'b1);
    chk("bp_res_c", result, 4'h4);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Back-to-back accumulator ops, then reset mid-stream.
    in_valid = 1'b1; op = 3'b100; a = 4'h3; b = 4'h0;
    step();
    op = 3'b010; a = 4'h5;
    step();
    chk("acc_load_res", result, 4'h3);
    chk("acc_load_acc", acc_out, 4'h3);
    op = 3'b011; a = 4'h1;
    step();
    in_valid = 1'b0;
`ifdef SATURATE_EN
    chk("acc_add_res", result, 4'h7);
    step();
    chk("acc_sub_res", result, 4'h6);
    chk("acc_sub_acc", acc_out, 4'h6);
`else
    chk("acc_add_res", result, 4'h8);
    step();
    chk("acc_sub_res", result, 4'h7);
    chk("acc_sub_acc", acc_out, 4'h7);
`endif
    chk("acc_sub_ov", out_valid, 1'b1);
    in_valid = 1'b1; op = 3'b010; a = 4'h2;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_ov",  out_valid, 1'b0);
    chk("mid_rst_acc", acc_out, 4'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_ov", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
